mux_rr_sched_8: RTL and testbench
=================================

MUX_RR_SCHED_8 -- requirements
Module: mux_rr_sched_8

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive cycles one grant is held (legal range 1..7).
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  8  request vector, req[i] from requester i.
REQ-005 Port: d  input  8  data bits, d[i] owned by requester i.
REQ-006 Port: gnt  output  8  registered one-hot grant, all-zero when idle.
REQ-007 Port: sel  output  3  registered binary index of granted requester.
REQ-008 Port: y  output  1  muxed data d[sel], gated by valid.
REQ-009 Port: valid  output  1  high when y carries live data from a requesting owner.

Function
REQ-010 FSM states IDLE and GRANT, plus a 3-bit burst counter cnt and a 3-bit last-winner pointer last.
REQ-011 Arbitration: search req from index (last+1) mod 8 upward with wrap; first asserted bit wins.
REQ-012 IDLE: req==0 -> stay IDLE; req!=0 at edge n -> GRANT from edge n, gnt/sel = winner, cnt=1, last=winner (one-cycle request-to-grant latency).
REQ-013 GRANT hold: req[sel]==1 and cnt<MAX_BURST -> keep gnt/sel, cnt increments.
REQ-014 GRANT release: req[sel]==0 or cnt==MAX_BURST -> re-arbitrate at the same edge.
REQ-015 Re-arbitration with any req bit set -> new winner granted on that edge, no idle bubble, cnt=1, last=winner.
REQ-016 Re-arbitration with req==0 -> IDLE, gnt=0, sel holds previous value, cnt=0.
REQ-017 Single continuous requester at burst limit wraps back to itself -> re-granted, cnt=1, gnt unchanged.
REQ-018 valid = (state==GRANT) & req[sel], combinational; y = valid ? d[sel] : 0.
REQ-019 Owner dropping req mid-grant -> valid and y fall to 0 in that same cycle, before the releasing edge.
REQ-020 Requests arriving or leaving on non-owners during GRANT do not change the current grant.
REQ-021 gnt is always zero or exactly one-hot and always equals 1<<sel while in GRANT.

Reset
REQ-022 rst high -> immediately state=IDLE, gnt=0, sel=0, cnt=0, last=7, valid=0, y=0, regardless of clk.
REQ-023 rst asserted mid-grant aborts the grant with no completion cycle.
REQ-024 First arbitration after reset starts search at index 0.

Verification
REQ-025 Reset then req=8'h01, d=8'h01 -> one edge later gnt=8'h01, sel=0, valid=1, y=1.
REQ-026 req=8'hFF held, MAX_BURST=4 -> grants 0,1,2,...,7,0 each held exactly 4 cycles, no gap cycles.
REQ-027 req=8'h10 only, held 10 cycles -> gnt stays 8'h10 throughout, cnt sequence 1,2,3,4,1,2,3,4,1,2.
REQ-028 Owner 2 drops req after 2 cycles while req[5]=1 -> valid=0 that cycle; next edge gnt=8'h20, sel=5.
REQ-029 req=8'h81 after last=0 -> winner 7; after release, winner 0 (wrap-around).
REQ-030 rst pulsed between clock edges during GRANT -> gnt=0, valid=0, y=0 at once; after release, req=8'h08 -> gnt=8'h08.

Source files
------------

// File: rtl/mux_rr_sched_8.sv
// Round-robin 8-way grant scheduler with burst limit; muxes the owner's data bit.
// Grant and index are registered; valid/y follow the owner's live request combinationally.
module mux_rr_sched_8 #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       y,
  output logic       valid
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   probe;
  logic            hold;

  // Nearest asserted request after last, wrapping; last itself is lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int k = N; k >= 1; k--) begin
      probe = IW'(last_q + IW'(k));
      if (req[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    hold    = (state_q == GRANT) && req[sel_q] && (cnt_q < IW'(MAX_BURST));
    if (hold) begin
      cnt_d = IW'(cnt_q + IW'(1));
    end else if (win_found) begin
      state_d = GRANT;
      gnt_d   = N'(1) << win_idx;
      sel_d   = win_idx;
      cnt_d   = IW'(1);
      last_d  = win_idx;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = (state_q == GRANT) && req[sel_q];
  assign y     = valid && d[sel_q];

endmodule

// File: tb/tb_mux_rr_sched_8.sv
// Bench for mux_rr_sched_8: integer-level arbitration model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mux_rr_sched_8;

  localparam int unsigned MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] d;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       y;
  logic       valid;

  int n_cmp = 0;
  int n_err = 0;

  mux_rr_sched_8 #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .d(d),
    .gnt(gnt), .sel(sel), .y(y), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: owner index (-1 when idle), consecutive cycles held, last winner, shown index.
  int m_owner, m_run, m_last, m_sel, m_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_run = 0; m_last = 7; m_sel = 0;
    end else if (m_owner >= 0 && req[3'(m_owner)] && m_run < int'(MAX_BURST)) begin
      m_run = m_run + 1;
    end else begin
      m_w = -1;
      for (int k = 1; k <= 8; k++)
        if (m_w < 0 && req[3'((m_last + k) % 8)]) m_w = (m_last + k) % 8;
      if (m_w >= 0) begin
        m_owner = m_w; m_sel = m_w; m_last = m_w; m_run = 1;
      end else begin
        m_owner = -1; m_run = 0;
      end
    end
  end

  logic [7:0] e_gnt;
  logic       e_valid, e_y;

  always @(negedge clk) begin
    e_gnt   = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    e_valid = (m_owner >= 0) && req[3'(m_owner)];
    e_y     = e_valid && d[3'(m_owner)];
    chk("model_gnt",   32'(gnt),   32'(e_gnt));
    chk("model_sel",   32'(sel),   32'(m_sel));
    chk("model_valid", 32'(valid), 32'(e_valid));
    chk("model_y",     32'(y),     32'(e_y));
    chk("onehot",      32'($countones(gnt) <= 1), 32'd1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] r, input logic [7:0] dd);
    req = r;
    d   = dd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    set_in(8'h00, 8'h00);
    step();
    rst = 1'b0;
  endtask

  int exp_run [10] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};
  logic [7:0] tbl_req [12] = '{8'h03, 8'h03, 8'h02, 8'h00, 8'h42, 8'h42,
                               8'hC3, 8'hC3, 8'h01, 8'h80, 8'h00, 8'h18};
  logic [7:0] tbl_d   [12] = '{8'hFF, 8'h01, 8'h02, 8'h00, 8'h40, 8'h02,
                               8'h81, 8'h42, 8'h01, 8'h80, 8'hFF, 8'h10};

  initial begin
    rst = 1'b0;
    req = 8'h00;
    d   = 8'h00;
    #1;

    // First grant after reset searches from index 0.
    do_reset();
    set_in(8'h01, 8'h01);
    step();
    chk("first_gnt", 32'(gnt), 32'h01);
    chk("first_sel", 32'(sel), 32'h0);
    chk("first_valid", 32'(valid), 32'h1);
    chk("first_y", 32'(y), 32'h1);

    // All requesting: each owner held MAX_BURST cycles, rotating without gaps.
    do_reset();
    set_in(8'hFF, 8'hAA);
    for (int c = 0; c <= 32; c++) begin
      step();
      chk("full_rot_gnt", 32'(gnt), 32'(8'd1 << ((c / 4) % 8)));
      chk("full_rot_valid", 32'(valid), 32'h1);
    end

    // Single requester re-granted to itself at the burst limit.
    do_reset();
    set_in(8'h10, 8'h10);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("solo_gnt", 32'(gnt), 32'h10);
      chk("solo_run", 32'(m_run), 32'(exp_run[c]));
    end

    // Owner drops mid-grant: valid falls before the edge, next owner follows.
    do_reset();
    set_in(8'h24, 8'h24);
    step();
    chk("drop_first_gnt", 32'(gnt), 32'h04);
    step();
    set_in(8'h20, 8'h24);
    #1;
    chk("drop_valid", 32'(valid), 32'h0);
    chk("drop_y", 32'(y), 32'h0);
    step();
    chk("drop_next_gnt", 32'(gnt), 32'h20);
    chk("drop_next_sel", 32'(sel), 32'h5);

    // Wrap-around: after last=0, 7 wins before 0.
    do_reset();
    set_in(8'h01, 8'h00);
    step();
    set_in(8'h00, 8'h00);
    step();
    chk("idle_gnt", 32'(gnt), 32'h00);
    chk("idle_sel_hold", 32'(sel), 32'h0);
    chk("idle_valid", 32'(valid), 32'h0);
    set_in(8'h81, 8'h81);
    step();
    chk("wrap_gnt7", 32'(gnt), 32'h80);
    chk("wrap_sel7", 32'(sel), 32'h7);
    step(); step(); step();
    chk("wrap_hold7", 32'(gnt), 32'h80);
    step();
    chk("wrap_gnt0", 32'(gnt), 32'h01);
    chk("wrap_sel0", 32'(sel), 32'h0);

    // Asynchronous reset mid-grant aborts immediately.
    do_reset();
    set_in(8'h04, 8'h04);
    step();
    step();
    chk("pre_abort_gnt", 32'(gnt), 32'h04);
    rst = 1'b1;
    #1;
    chk("abort_gnt", 32'(gnt), 32'h00);
    chk("abort_valid", 32'(valid), 32'h0);
    chk("abort_y", 32'(y), 32'h0);
    #1;
    rst = 1'b0;
    set_in(8'h08, 8'h08);
    step();
    chk("post_abort_gnt", 32'(gnt), 32'h08);
    chk("post_abort_sel", 32'(sel), 32'h3);

    // Mixed directed vectors checked by the model alone.
    for (int i = 0; i < 12; i++) begin
      set_in(tbl_req[i], tbl_d[i]);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
